vfpm_sequencer: RTL and testbench
=================================

VFPM_SEQUENCER -- requirements
Module: vfpm_sequencer

Interface
REQ-001 Parameter VLEN_MAX, default 8: maximum elements per vector operation.
REQ-002 Parameter MUL_LAT, default 3: fixed datapath latency in cycles from dp_start to dp_result valid, minimum 1.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a vector operation; sampled only in IDLE.
REQ-006 vec_len  input  4  element count for the operation, legal 1..VLEN_MAX.
REQ-007 op_rd  output  1  operand read strobe to operand register file.
REQ-008 op_addr  output  3  element index being read.
REQ-009 a_in, b_in  input  32 each  fp32 operands, returned combinationally for op_addr.
REQ-010 dp_start  output  1  issue strobe to the multiply/normalize datapath.
REQ-011 dp_a, dp_b  output  32 each  operands to datapath, pass-through of a_in/b_in.
REQ-012 dp_result  input  32  fp32 product, valid MUL_LAT cycles after the matching dp_start.
REQ-013 dp_overflow  input  1  exponent overflow flag, aligned with dp_result.
REQ-014 res_we, res_addr, res_data  output  1/3/32  result write port to result register file.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse at operation completion.
REQ-017 err  output  1  one-cycle pulse when start carries an illegal vec_len.
REQ-018 ovf_mask  output  VLEN_MAX  per-element overflow flags for the last operation.
REQ-019 ovf_any  output  1  OR of ovf_mask.

Function
REQ-020 The FSM SHALL have states IDLE, ISSUE, DRAIN, DONE.
REQ-021 IDLE with start=1 and vec_len in 1..VLEN_MAX SHALL latch vec_len, clear ovf_mask and the element index, and go to ISSUE.
REQ-022 IDLE with start=1 and vec_len 0 or >VLEN_MAX SHALL pulse err for one cycle and stay in IDLE.
REQ-023 Each ISSUE cycle SHALL assert op_rd and dp_start with op_addr equal to the element index, then increment the index.
REQ-024 ISSUE SHALL go to DRAIN after issuing element vec_len-1; no issue occurs outside ISSUE.
REQ-025 A tag pipeline of depth MUL_LAT SHALL carry {valid, index} for each issue; at its output, res_we=valid and res_addr=index.
REQ-026 When res_we=1 and dp_overflow=0, res_data SHALL equal dp_result.
REQ-027 When res_we=1 and dp_overflow=1, res_data SHALL be {dp_result[31], 8'hFF, 23'h0}, and ovf_mask[index] SHALL be set.
REQ-028 DRAIN SHALL go to DONE the cycle after the last outstanding result is written (tag pipeline empty).
REQ-029 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-030 Latency: with start sampled at cycle 0, element i issues at cycle 1+i, writes at 1+i+MUL_LAT, and done occurs at cycle vec_len+MUL_LAT+1.
REQ-031 start while busy SHALL be ignored, with no err pulse.
REQ-032 ovf_mask and ovf_any SHALL hold until the next accepted start.
REQ-033 Arithmetic: the index is 3-bit and never wraps, because vec_len is at most 8 and the last index is vec_len-1.

Reset
REQ-034 Asserting reset at any time, including mid-operation, SHALL immediately force IDLE and clear the tag pipeline, index and ovf_mask.
REQ-035 During reset, all outputs SHALL be 0, and no res_we SHALL follow for in-flight elements.

Structure
REQ-036 Package vfpm_pkg SHALL hold VLEN_MAX, MUL_LAT defaults, the FSM state encoding and FP32_INF_EXP (8'hFF).
REQ-037 Sub-module vfpm_tag_pipe (parameterised shift register of {valid, index}, async active-low reset) SHALL be instantiated once.

Verification
REQ-038 vec_len=4, MUL_LAT=3, no overflow: dp_start at cycles 1-4, res_we at cycles 4-7 with res_addr 0-3, done at cycle 8, ovf_mask=0.
REQ-039 vec_len=8 with dp_overflow on element 5, sign 1: res_data[5]=32'hFF800000, ovf_mask=8'h20, ovf_any=1.
REQ-040 start with vec_len=0, then vec_len=9: err pulses each time, busy stays 0, no dp_start.
REQ-041 start pulsed again during ISSUE of a vec_len=3 operation: ignored; exactly 3 results are written and one done pulse occurs.
REQ-042 reset asserted at cycle 3 of a vec_len=6 operation: all outputs 0 and no further res_we; a new start after release runs normally.
REQ-043 vec_len=1: one issue at cycle 1, one write at cycle 1+MUL_LAT, done at cycle MUL_LAT+2.

Source files
------------

// File: rtl/vfpm_pkg.sv
// Shared definitions for the vector fp32 multiply sequencer:
// default sizing, FSM encoding and the fp32 infinity exponent.
package vfpm_pkg;

   localparam int VLEN_MAX_DEF = 8;
   localparam int MUL_LAT_DEF  = 3;

   localparam logic [7:0] FP32_INF_EXP = 8'hFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/vfpm_if.sv
// Operand-read, datapath and result-write buses between the
// sequencer (master) and its register files / datapath (slave).
interface vfpm_if;

   logic        op_rd;
   logic [2:0]  op_addr;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic        dp_start;
   logic [31:0] dp_a;
   logic [31:0] dp_b;
   logic [31:0] dp_result;
   logic        dp_overflow;
   logic        res_we;
   logic [2:0]  res_addr;
   logic [31:0] res_data;

   modport master (
      output op_rd, op_addr, dp_start, dp_a, dp_b,
      output res_we, res_addr, res_data,
      input  a_in, b_in, dp_result, dp_overflow
   );

   modport slave (
      input  op_rd, op_addr, dp_start, dp_a, dp_b,
      input  res_we, res_addr, res_data,
      output a_in, b_in, dp_result, dp_overflow
   );

endinterface

// File: rtl/vfpm_tag_pipe.sv
// Shift register carrying {valid, index} alongside the datapath so
// each result arrives tagged with the element it belongs to.
module vfpm_tag_pipe #(
   parameter int DEPTH = 3,
   parameter int IW    = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_vld,
   input  logic [IW-1:0] in_idx,
   output logic          out_vld,
   output logic [IW-1:0] out_idx,
   output logic          pending
);

   logic [DEPTH-1:0] vld_q, vld_d;
   logic [IW-1:0]    idx_q [DEPTH];
   logic [IW-1:0]    idx_d [DEPTH];

   always_comb begin
      vld_d[0] = in_vld;
      idx_d[0] = in_idx;
      for (int i = 1; i < DEPTH; i++) begin
         vld_d[i] = vld_q[i-1];
         idx_d[i] = idx_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int i = 0; i < DEPTH; i++) idx_q[i] <= '0;
      end else begin
         vld_q <= vld_d;
         idx_q <= idx_d;
      end
   end

   // Anything still in flight beyond the stage being written now
   always_comb begin
      pending = 1'b0;
      for (int i = 0; i < DEPTH - 1; i++) pending = pending | vld_q[i];
   end

   assign out_vld = vld_q[DEPTH-1];
   assign out_idx = idx_q[DEPTH-1];

endmodule

// File: rtl/vfpm_sequencer.sv
// Issues vec_len element multiplies to a fixed-latency datapath and
// writes tagged results back, saturating overflows to signed infinity.
module vfpm_sequencer
   import vfpm_pkg::*;
#(
   parameter int VLEN_MAX = VLEN_MAX_DEF,
   parameter int MUL_LAT  = MUL_LAT_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [3:0]          vec_len,
   vfpm_if.master              bus,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [VLEN_MAX-1:0] ovf_mask,
   output logic                ovf_any
);

   localparam logic [3:0] LEN_MAX = 4'(VLEN_MAX);

   state_t                state_q, state_d;
   logic [3:0]            len_q, len_d;
   logic [2:0]            idx_q, idx_d;
   logic [VLEN_MAX-1:0]   mask_q, mask_d;
   logic                  err_q, err_d;
   logic                  issue, legal, last;
   logic                  out_vld, pending;
   logic [2:0]            out_idx;

   assign legal = (vec_len != 4'd0) && (vec_len <= LEN_MAX);
   assign last  = (({1'b0, idx_q} + 4'd1) == len_q);

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      mask_d  = mask_q;
      err_d   = 1'b0;
      issue   = 1'b0;
      if (out_vld && bus.dp_overflow) mask_d[out_idx] = 1'b1;
      unique case (state_q)
         IDLE: begin
            if (start && legal) begin
               len_d   = vec_len;
               idx_d   = 3'd0;
               mask_d  = '0;
               state_d = ISSUE;
            end else if (start) begin
               err_d = 1'b1;
            end
         end
         ISSUE: begin
            issue = 1'b1;
            if (last) state_d = DRAIN;
            else      idx_d   = idx_q + 3'd1;
         end
         DRAIN: begin
            if (!pending) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         len_q   <= '0;
         idx_q   <= '0;
         mask_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         mask_q  <= mask_d;
         err_q   <= err_d;
      end
   end

   vfpm_tag_pipe #(
      .DEPTH (MUL_LAT),
      .IW    (3)
   ) u_tag_pipe (
      .clk     (clk),
      .rst_n   (reset),
      .in_vld  (issue),
      .in_idx  (idx_q),
      .out_vld (out_vld),
      .out_idx (out_idx),
      .pending (pending)
   );

   // Bus outputs are gated so nothing leaks out while idle or in reset
   assign bus.op_rd    = issue;
   assign bus.op_addr  = issue ? idx_q : 3'd0;
   assign bus.dp_start = issue;
   assign bus.dp_a     = issue ? bus.a_in : 32'd0;
   assign bus.dp_b     = issue ? bus.b_in : 32'd0;
   assign bus.res_we   = out_vld;
   assign bus.res_addr = out_vld ? out_idx : 3'd0;

   always_comb begin
      bus.res_data = 32'd0;
      if (out_vld) begin
         if (bus.dp_overflow)
            bus.res_data = {bus.dp_result[31], FP32_INF_EXP, 23'h0};
         else
            bus.res_data = bus.dp_result;
      end
   end

   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign err      = err_q;
   assign ovf_mask = mask_q;
   assign ovf_any  = |mask_q;

endmodule

// File: tb/tb_vfpm_sequencer.sv
// Randomized bench for vfpm_sequencer against a cycle-schedule model
// of issue, write-back, completion and overflow reporting.
module tb_vfpm_sequencer;

  localparam int LAT = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] vec_len = 4'd0;
  logic       busy, done, err, ovf_any;
  logic [7:0] ovf_mask;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] a_mem [8];
  logic [31:0] b_mem [8];
  logic [7:0]  ovf_en = 8'h00;
  logic [7:0]  last_mask = 8'h00;

  logic [31:0] dpv [LAT];
  logic        dpo [LAT];

  vfpm_if bus();

  vfpm_sequencer #(
    .VLEN_MAX (8),
    .MUL_LAT  (LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .vec_len  (vec_len),
    .bus      (bus.master),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .ovf_mask (ovf_mask),
    .ovf_any  (ovf_any)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mul_ref(
    input logic [31:0] a,
    input logic [31:0] b
  );
    return a ^ {b[15:0], b[31:16]};
  endfunction

  function automatic logic [31:0] exp_data(input int i);
    logic [31:0] r;
    r = mul_ref(a_mem[i], b_mem[i]);
    return ovf_en[i] ? {r[31], 8'hFF, 23'h0} : r;
  endfunction

  always_comb begin
    bus.a_in        = a_mem[bus.op_addr];
    bus.b_in        = b_mem[bus.op_addr];
    bus.dp_result   = dpv[LAT-1];
    bus.dp_overflow = dpo[LAT-1];
  end

  always @(posedge clk) begin
    dpv[0] <= mul_ref(bus.dp_a, bus.dp_b);
    dpo[0] <= bus.dp_start & ovf_en[bus.op_addr];
    for (int i = 1; i < LAT; i++) begin
      dpv[i] <= dpv[i-1];
      dpo[i] <= dpo[i-1];
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic load(input logic [7:0] ov);
    for (int i = 0; i < 8; i++) begin
      a_mem[i] = $urandom;
      b_mem[i] = $urandom;
    end
    ovf_en = ov;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_mask"}, 32'(ovf_mask), 32'd0);
    chk({tag, "_any"}, 32'(ovf_any), 32'd0);
    chk({tag, "_op_rd"}, 32'(bus.op_rd), 32'd0);
    chk({tag, "_op_addr"}, 32'(bus.op_addr), 32'd0);
    chk({tag, "_dp_start"}, 32'(bus.dp_start), 32'd0);
    chk({tag, "_dp_a"}, bus.dp_a, 32'd0);
    chk({tag, "_res_we"}, 32'(bus.res_we), 32'd0);
    chk({tag, "_res_data"}, bus.res_data, 32'd0);
  endtask

  // Element i issues in cycle 1+i, writes in 1+i+LAT; done in len+LAT+1
  task automatic run_op(input int len, input bit poke);
    int writes = 0;
    int dones = 0;
    logic [7:0] exp_mask = 8'h00;
    for (int i = 0; i < len; i++)
      if (ovf_en[i]) exp_mask[i] = 1'b1;
    @(negedge clk);
    start = 1'b1;
    vec_len = 4'(len);
    for (int c = 1; c <= len + LAT + 2; c++) begin
      @(negedge clk);
      chk("dp_start", 32'(bus.dp_start), 32'(c <= len));
      chk("op_rd", 32'(bus.op_rd), 32'(c <= len));
      if (c <= len) begin
        chk("op_addr", 32'(bus.op_addr), 32'(c - 1));
        chk("dp_a", bus.dp_a, a_mem[c-1]);
      end
      chk("res_we", 32'(bus.res_we), 32'(c > LAT && c <= len + LAT));
      if (c > LAT && c <= len + LAT) begin
        chk("res_addr", 32'(bus.res_addr), 32'(c - 1 - LAT));
        chk("res_data", bus.res_data, exp_data(c - 1 - LAT));
      end
      chk("done", 32'(done), 32'(c == len + LAT + 1));
      chk("busy", 32'(busy), 32'(c <= len + LAT + 1));
      chk("err_op", 32'(err), 32'd0);
      writes += int'(bus.res_we);
      dones += int'(done);
      start = poke && (c == 2);
      vec_len = poke ? 4'd2 : 4'(len);
    end
    start = 1'b0;
    chk("n_writes", 32'(writes), 32'(len));
    chk("n_done", 32'(dones), 32'd1);
    chk("ovf_mask", 32'(ovf_mask), 32'(exp_mask));
    chk("ovf_any", 32'(ovf_any), 32'(exp_mask != 8'h00));
    last_mask = exp_mask;
  endtask

  task automatic bad_start(input logic [3:0] len);
    @(negedge clk);
    start = 1'b1;
    vec_len = len;
    @(negedge clk);
    start = 1'b0;
    chk("err_pulse", 32'(err), 32'd1);
    chk("err_busy", 32'(busy), 32'd0);
    chk("err_dp_start", 32'(bus.dp_start), 32'd0);
    @(negedge clk);
    chk("err_clear", 32'(err), 32'd0);
    chk("err_busy2", 32'(busy), 32'd0);
    chk("err_mask_hold", 32'(ovf_mask), 32'(last_mask));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      a_mem[i] = 32'd0;
      b_mem[i] = 32'd0;
    end
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b1;

    load(8'h00);
    run_op(4, 1'b0);

    load(8'h20);
    a_mem[5] = 32'h8000_0000;
    b_mem[5] = 32'h0000_0000;
    run_op(8, 1'b0);
    chk("ovf5_value", exp_data(5), 32'hFF80_0000);
    chk("ovf_mask_20", 32'(ovf_mask), 32'h20);

    bad_start(4'd0);
    bad_start(4'd9);
    bad_start(4'(15));

    load(8'($urandom));
    run_op(3, 1'b1);

    load(8'($urandom));
    run_op(1, 1'b0);

    for (int k = 0; k < 8; k++) begin
      load(8'($urandom));
      run_op(int'($urandom_range(1, 8)), 1'($urandom_range(0, 1)));
    end

    // Reset in cycle 3 of a 6-element operation
    load(8'hFF);
    @(negedge clk);
    start = 1'b1;
    vec_len = 4'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_hold_we", 32'(bus.res_we), 32'd0);
      chk("rst_hold_busy", 32'(busy), 32'd0);
    end
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post_rst_we", 32'(bus.res_we), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end

    load(8'($urandom));
    run_op(6, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
